// File: rtl/dino_pkg.sv
// dino_pkg
// Shared types and default constants for the dino game-state engine.
//   game_state_t     : 2-bit game state encoding (IDLE=0, RUN=1, JUMP=2, DEAD=3)
//   DEF_*            : default geometry / physics / score parameters
//   BCD_W            : width of one BCD score digit
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_JUMP = 2'd2,
        ST_DEAD = 2'd3
    } game_state_t;

    localparam int DEF_Y_W          = 10;
    localparam int DEF_GROUND_Y     = 400;
    localparam int DEF_JUMP_V0      = 12;
    localparam int DEF_GRAVITY      = 1;
    localparam int DEF_SCORE_DIGITS = 4;

    localparam int BCD_W = 4;

endpackage

// File: rtl/dino_game_core_if.sv
// dino_game_core_if
// Bundles the per-frame control inputs and the registered game outputs
// exchanged between the register file / renderer side and the game core.
//   master : drives frame_tick, ctrl_start, ctrl_jump, collision; reads outputs
//   slave  : the game core; reads controls, drives dino_y, game_state,
//            score_bcd, speed, game_over
interface dino_game_core_if
    import dino_pkg::*;
#(
    parameter int Y_W          = DEF_Y_W,
    parameter int SCORE_DIGITS = DEF_SCORE_DIGITS
) ();

    logic                            frame_tick;
    logic                            ctrl_start;
    logic                            ctrl_jump;
    logic                            collision;
    logic [Y_W-1:0]                  dino_y;
    game_state_t                     game_state;
    logic [BCD_W*SCORE_DIGITS-1:0]   score_bcd;
    logic [3:0]                      speed;
    logic                            game_over;

    modport master (
        output frame_tick, ctrl_start, ctrl_jump, collision,
        input  dino_y, game_state, score_bcd, speed, game_over
    );

    modport slave (
        input  frame_tick, ctrl_start, ctrl_jump, collision,
        output dino_y, game_state, score_bcd, speed, game_over
    );

endinterface

// File: rtl/dino_bcd_counter.sv
// dino_bcd_counter
// Chained BCD up-counter that saturates at all-9s.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : add one when not saturated
//   count      : packed BCD value, digit 0 in the LSBs
//   wrap100    : combinational pulse, high in the cycle whose increment
//                rolls the two low digits from 99 to 00
module dino_bcd_counter
    import dino_pkg::*;
#(
    parameter int SCORE_DIGITS = DEF_SCORE_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          inc,
    output logic [BCD_W*SCORE_DIGITS-1:0] count,
    output logic                          wrap100
);

    localparam int W = BCD_W * SCORE_DIGITS;
    localparam logic [W-1:0]         ALL_NINES = {SCORE_DIGITS{BCD_W'(9)}};
    localparam logic [2*BCD_W-1:0]   LOW_99    = {BCD_W'(9), BCD_W'(9)};

    logic [W-1:0] count_q, count_d;
    logic         saturated;
    logic         carry;

    // Ripple the +1 through the digits; a digit at 9 rolls to 0 and passes
    // the carry on, the first digit below 9 absorbs it.
    always_comb begin
        count_d   = count_q;
        carry     = 1'b1;
        saturated = (count_q == ALL_NINES);
        if (clr) begin
            count_d = '0;
        end else if (inc && !saturated) begin
            for (int i = 0; i < SCORE_DIGITS; i++) begin
                if (carry) begin
                    if (count_q[i*BCD_W +: BCD_W] == BCD_W'(9)) begin
                        count_d[i*BCD_W +: BCD_W] = '0;
                    end else begin
                        count_d[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] + BCD_W'(1);
                        carry = 1'b0;
                    end
                end
            end
        end
        wrap100 = inc && !clr && !saturated && (count_q[2*BCD_W-1:0] == LOW_99);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/dino_game_core.sv
// dino_game_core
// Frame-rate game-state engine: edge-detects the start/jump control bits,
// runs the IDLE/RUN/JUMP/DEAD machine with jump physics on each frame_tick,
// and keeps a saturating BCD score and a 1..15 speed level.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   bus (slave)   : frame_tick, ctrl_start, ctrl_jump, collision in;
//                   dino_y, game_state, score_bcd, speed, game_over out
//                   (all outputs registered)
module dino_game_core
    import dino_pkg::*;
#(
    parameter int Y_W          = DEF_Y_W,
    parameter int GROUND_Y     = DEF_GROUND_Y,
    parameter int JUMP_V0      = DEF_JUMP_V0,
    parameter int GRAVITY      = DEF_GRAVITY,
    parameter int SCORE_DIGITS = DEF_SCORE_DIGITS
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    dino_game_core_if.slave  bus
);

    localparam int                 SCORE_W   = BCD_W * SCORE_DIGITS;
    localparam logic [Y_W-1:0]     GROUND    = Y_W'(GROUND_Y);
    localparam logic signed [Y_W:0] V0_S     = (Y_W+1)'(JUMP_V0);
    localparam logic signed [Y_W:0] GRAV_S   = (Y_W+1)'(GRAVITY);
    localparam logic [3:0]         SPEED_MAX = 4'd15;

    game_state_t           state_q, state_d;
    logic [Y_W-1:0]        height_q, height_d;
    logic signed [Y_W:0]   vel_q, vel_d;
    logic                  start_prev_q, start_prev_d;
    logic                  jump_prev_q, jump_prev_d;
    logic                  start_pend_q, start_pend_d;
    logic                  jump_pend_q, jump_pend_d;
    logic [3:0]            speed_q, speed_d;
    logic [Y_W-1:0]        dino_y_q, dino_y_d;
    logic                  game_over_q, game_over_d;

    logic                  start_pend;
    logic                  jump_pend;
    logic                  restart;
    logic                  score_clr;
    logic                  score_inc;
    logic                  score_wrap;
    logic [SCORE_W-1:0]    score;
    logic signed [Y_W:0]   sum;

    dino_bcd_counter #(
        .SCORE_DIGITS (SCORE_DIGITS)
    ) u_score (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .clr     (score_clr),
        .inc     (score_inc),
        .count   (score),
        .wrap100 (score_wrap)
    );

    assign sum = $signed({1'b0, height_q}) + vel_q;

    // Edge detect, pending flags and the game state machine. A control edge
    // in the tick cycle itself is folded into the pending value used by that
    // tick. The launch tick already applies one frame of gravity, so the
    // stored velocity after launch is V0 - GRAVITY.
    always_comb begin
        start_prev_d = bus.ctrl_start;
        jump_prev_d  = bus.ctrl_jump;
        start_pend   = start_pend_q | (bus.ctrl_start & ~start_prev_q);
        jump_pend    = jump_pend_q  | (bus.ctrl_jump  & ~jump_prev_q);
        start_pend_d = start_pend;
        jump_pend_d  = jump_pend;
        state_d      = state_q;
        height_d     = height_q;
        vel_d        = vel_q;
        score_clr    = 1'b0;
        score_inc    = 1'b0;
        restart      = 1'b0;
        if (bus.frame_tick) begin
            start_pend_d = 1'b0;
            jump_pend_d  = 1'b0;
            unique case (state_q)
                ST_IDLE, ST_DEAD: begin
                    restart = start_pend;
                end
                ST_RUN: begin
                    if (bus.collision) begin
                        state_d = ST_DEAD;
                    end else begin
                        score_inc = 1'b1;
                        if (jump_pend) begin
                            state_d  = ST_JUMP;
                            height_d = Y_W'(JUMP_V0);
                            vel_d    = V0_S - GRAV_S;
                        end
                    end
                end
                ST_JUMP: begin
                    if (bus.collision) begin
                        state_d = ST_DEAD;
                    end else begin
                        score_inc = 1'b1;
                        if (sum[Y_W] || (sum == '0)) begin
                            state_d  = ST_RUN;
                            height_d = '0;
                            vel_d    = '0;
                        end else begin
                            if (sum > $signed({1'b0, GROUND})) begin
                                height_d = GROUND;
                            end else begin
                                height_d = sum[Y_W-1:0];
                            end
                            vel_d = vel_q - GRAV_S;
                        end
                    end
                end
                default: ;
            endcase
            if (restart) begin
                state_d   = ST_RUN;
                height_d  = '0;
                vel_d     = '0;
                score_clr = 1'b1;
            end
        end
        dino_y_d    = GROUND - height_d;
        game_over_d = (state_d == ST_DEAD);
    end

    // Speed follows the score's hundreds rollover; kept apart from the FSM
    // block because wrap100 is derived from that block's inc/clr.
    always_comb begin
        speed_d = speed_q;
        if (bus.frame_tick) begin
            if (restart) begin
                speed_d = 4'd1;
            end else if (score_wrap && (speed_q != SPEED_MAX)) begin
                speed_d = speed_q + 4'd1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= ST_IDLE;
            height_q     <= '0;
            vel_q        <= '0;
            start_prev_q <= 1'b0;
            jump_prev_q  <= 1'b0;
            start_pend_q <= 1'b0;
            jump_pend_q  <= 1'b0;
            speed_q      <= 4'd1;
            dino_y_q     <= GROUND;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            height_q     <= height_d;
            vel_q        <= vel_d;
            start_prev_q <= start_prev_d;
            jump_prev_q  <= jump_prev_d;
            start_pend_q <= start_pend_d;
            jump_pend_q  <= jump_pend_d;
            speed_q      <= speed_d;
            dino_y_q     <= dino_y_d;
            game_over_q  <= game_over_d;
        end
    end

    assign bus.dino_y     = dino_y_q;
    assign bus.game_state = state_q;
    assign bus.score_bcd  = score;
    assign bus.speed      = speed_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_dino_game_core.sv
// tb_dino_game_core
// Scoreboard bench for dino_game_core: each issued frame_tick pushes the
// hand-derived expected outputs; a monitor pops and compares them on the
// falling edge after the DUT has registered that tick.
module tb_dino_game_core;
    import dino_pkg::*;

    typedef struct {
        game_state_t st;
        logic [9:0]  y;
        logic [15:0] score;
        logic [3:0]  speed;
        logic        over;
        string       name;
    } exp_t;

    logic ACLK    = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    dino_game_core_if #(.Y_W(10), .SCORE_DIGITS(4)) bus ();

    dino_game_core #(
        .Y_W          (10),
        .GROUND_Y     (400),
        .JUMP_V0      (12),
        .GRAVITY      (1),
        .SCORE_DIGITS (4)
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_score = 0;
    logic tick_d;

    // Heights in the air, launch tick first; the tick after the last entry lands.
    int jump_h [24] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78,
                        78, 77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] speed_of(input int s);
        int sp;
        sp = 1 + s / 100;
        if (sp > 15) sp = 15;
        return 4'(sp);
    endfunction

    function automatic exp_t make_exp(input game_state_t st, input int y, input int score,
                                      input int spd, input logic over, input string name);
        exp_t e;
        e.st    = st;
        e.y     = 10'(y);
        e.score = to_bcd(score);
        e.speed = 4'(spd);
        e.over  = over;
        e.name  = name;
        return e;
    endfunction

    task automatic check_output(input exp_t e);
        n_tests++;
        if (bus.game_state !== e.st || bus.dino_y !== e.y || bus.score_bcd !== e.score ||
            bus.speed !== e.speed || bus.game_over !== e.over) begin
            n_fail++;
            $display("[TB] FAIL %s: got state=%0d y=%0d score=%h speed=%0d over=%0b, expected state=%0d y=%0d score=%h speed=%0d over=%0b",
                     e.name, bus.game_state, bus.dino_y, bus.score_bcd, bus.speed, bus.game_over,
                     e.st, e.y, e.score, e.speed, e.over);
        end
    endtask

    // One isolated frame tick with the given control/collision levels.
    task automatic apply_stimulus(input logic start, input logic jump, input logic coll, input exp_t e);
        @(negedge ACLK);
        bus.frame_tick = 1'b1;
        bus.ctrl_start = start;
        bus.ctrl_jump  = jump;
        bus.collision  = coll;
        exp_q.push_back(e);
        @(negedge ACLK);
        bus.frame_tick = 1'b0;
        bus.ctrl_start = 1'b0;
        bus.ctrl_jump  = 1'b0;
        bus.collision  = 1'b0;
    endtask

    // One-cycle control pulse between ticks.
    task automatic pulse_ctrl(input logic start, input logic jump);
        @(negedge ACLK);
        bus.ctrl_start = start;
        bus.ctrl_jump  = jump;
        @(negedge ACLK);
        bus.ctrl_start = 1'b0;
        bus.ctrl_jump  = 1'b0;
    endtask

    // Back-to-back ticks in RUN, expected score/speed from a running count.
    task automatic run_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            bus.frame_tick = 1'b1;
            if (model_score < 9999) model_score++;
            exp_q.push_back(make_exp(ST_RUN, 400, model_score, int'(speed_of(model_score)), 1'b0,
                                     $sformatf("score run %0d", model_score)));
        end
        @(negedge ACLK);
        bus.frame_tick = 1'b0;
    endtask

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) tick_d <= 1'b0;
        else          tick_d <= bus.frame_tick;
    end

    // Monitor: outputs of a tick are valid from the rising edge after it.
    always @(negedge ACLK) begin
        if (tick_d) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected tick: got no expected entry, required one");
            end else begin
                check_output(exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.frame_tick = 1'b0;
        bus.ctrl_start = 1'b0;
        bus.ctrl_jump  = 1'b0;
        bus.collision  = 1'b0;

        #12;
        check_output(make_exp(ST_IDLE, 400, 0, 1, 1'b0, "reset values"));
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Start from IDLE, then five scored ticks.
        pulse_ctrl(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_RUN, 400, 0, 1, 1'b0, "start"));
        for (int i = 1; i <= 5; i++)
            apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_RUN, 400, i, 1, 1'b0, "run score"));

        // Jump arc; an extra jump edge mid-air must not matter.
        pulse_ctrl(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_JUMP, 400 - jump_h[0], 6, 1, 1'b0, "jump launch"));
        for (int k = 1; k < 24; k++) begin
            if (k == 4) pulse_ctrl(1'b0, 1'b1);
            apply_stimulus(1'b0, 1'b0, 1'b0,
                           make_exp(ST_JUMP, 400 - jump_h[k], 6 + k, 1, 1'b0, $sformatf("jump arc %0d", k)));
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_RUN, 400, 30, 1, 1'b0, "landing"));
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_RUN, 400, 31, 1, 1'b0, "no double jump"));

        // Jump and collision on the same tick: collision wins, no score.
        pulse_ctrl(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1, make_exp(ST_DEAD, 400, 31, 1, 1'b1, "jump+collision"));
        apply_stimulus(1'b0, 1'b1, 1'b1, make_exp(ST_DEAD, 400, 31, 1, 1'b1, "dead frozen 1"));
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_DEAD, 400, 31, 1, 1'b1, "dead frozen 2"));

        // Start edge in the tick cycle plus collision while DEAD: restart.
        apply_stimulus(1'b1, 1'b0, 1'b1, make_exp(ST_RUN, 400, 0, 1, 1'b0, "restart from dead"));

        // Long run through 99->100, speed saturation and score saturation.
        model_score = 0;
        run_burst(10005);

        // Jump with a saturated score, then asynchronous reset mid-air.
        pulse_ctrl(1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_JUMP, 388, 9999, 15, 1'b0, "jump saturated"));
        apply_stimulus(1'b0, 1'b0, 1'b0, make_exp(ST_JUMP, 377, 9999, 15, 1'b0, "jump arc sat"));
        @(posedge ACLK);
        #3;
        ARESETN = 1'b0;
        bus.ctrl_start = 1'b1;
        #1;
        check_output(make_exp(ST_IDLE, 400, 0, 1, 1'b0, "async reset"));
        @(negedge ACLK);
        #2;
        ARESETN = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        apply_stimulus(1'b1, 1'b0, 1'b0, make_exp(ST_RUN, 400, 0, 1, 1'b0, "start held through reset"));

        @(negedge ACLK);
        @(negedge ACLK);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
